instruction_fetch_stage: RTL and testbench
==========================================

Name: instruction_fetch_stage

Overview:
- Fetch stage and IF/ID pipeline register directly upstream of the instruction decoder/Controller.
- Holds the PC and drives the instruction-memory address.
- Applies jump, jump-register and branch redirects with priority.
- Latches the fetched word and splits it into the fields the decoder consumes (OPCode, Function, TargetReg, etc.), with stall/flush control and fetch/stall performance counters.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the fetch and stall counters (saturating).

Ports:
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  reset; asynchronous, active-low (assert async, deassert sync to Clk).
- IMemAddr  out  32  byte address to instruction memory = PC (combinational read).
- IMemData  in  32  instruction word at IMemAddr, valid same cycle.
- Stall  in  1  hold PC and IF/ID (load-use hazard).
- BranchTaken  in  1  EX-stage branch resolved taken.
- BranchTarget  in  32  EX-stage branch target address.
- Jump  in  1  Controller Jump for the instruction currently in IF/ID.
- JumpReg  in  1  Controller JumpReg for the instruction in IF/ID.
- JumpRegAddr  in  32  rs value for JR.
- IF_ID_Valid  out  1  IF/ID holds a real instruction (0 = bubble).
- IF_ID_Instr  out  32  latched instruction.
- IF_ID_PCPlus4  out  32  PC+4 of the latched instruction.
- OPCode  out  6  IF_ID_Instr[31:26].
- Rs  out  5  IF_ID_Instr[25:21].
- TargetReg  out  5  IF_ID_Instr[20:16].
- Rd  out  5  IF_ID_Instr[15:11].
- Shamt  out  5  IF_ID_Instr[10:6].
- Function  out  6  IF_ID_Instr[5:0].
- ImmSExt  out  32  sign-extended IF_ID_Instr[15:0].
- FetchCount  out  CNT_W  instructions latched valid into IF/ID.
- StallCount  out  CNT_W  cycles with Stall high and no redirect.

Behaviour:
- Reset (Rst_n=0, immediate):
  - PC=RESET_PC.
  - IF_ID_Instr=0 (nop), IF_ID_Valid=0, IF_ID_PCPlus4=0.
  - FetchCount=0, StallCount=0.
  - Field outputs are derived from IF_ID_Instr and therefore all read 0.
- Reset mid-operation: any pending redirect or stall is discarded. The first fetch after release is RESET_PC.
- Field outputs and IMemAddr are purely combinational from registers. The decoder sees an instruction one cycle after its address was presented.
- Next-PC priority, evaluated each rising edge:
  1. BranchTaken → PC=BranchTarget.
  2. JumpReg → PC=JumpRegAddr.
  3. Jump → PC={IF_ID_PCPlus4[31:28], IF_ID_Instr[25:0], 2'b00}.
  4. Stall → PC unchanged.
  5. Otherwise → PC=PC+4, wrapping modulo 2^32.
- Redirect targets are word-aligned: bits[1:0] forced to 00.
- Jump/JumpReg are honoured only when IF_ID_Valid=1; they are ignored on a bubble.
- IF/ID update, evaluated each rising edge:
  - BranchTaken: flush. Instr=0, Valid=0, PCPlus4=0. This kills the wrong-path fetch (1-cycle bubble into ID).
  - Else Jump/JumpReg (valid): flush, same as above. Exactly one bubble.
  - Else Stall: hold all IF/ID registers.
  - Else: Instr=IMemData, PCPlus4=PC+4, Valid=1.
- Simultaneous events:
  - Redirect beats Stall.
  - BranchTaken beats JumpReg/Jump; the jump in IF/ID is younger and on the wrong path.
  - JumpReg beats Jump.
- Counters: both saturate at all-ones with no wrap.
  - FetchCount increments on each edge where IF/ID loads with Valid=1.
  - StallCount increments on each edge where Stall=1 and no redirect is taken.
- No FSM beyond PC/IF-ID state. Flush produces exactly one bubble per redirect edge.

Test Plan:
- Reset release, RESET_PC=0, IMemData=addr-tagged words, no stall → IMemAddr 0,4,8,…. IF_ID_PCPlus4 lags by one cycle (4,8,12). Valid=1 from the first edge. FetchCount=N after N edges.
- IF/ID holds 0x08000010 (J) with PCPlus4=0x00400008, Jump=1 → next PC=0x00000040 (={0x0, 0x0000010, 00}). IF/ID becomes a bubble for one cycle, then the instruction from 0x40.
- Stall high 3 cycles at PC=0x20 → PC stays 0x20, IF/ID unchanged, StallCount+3, FetchCount unchanged. On release PC goes 0x24 next edge.
- Stall=1, BranchTaken=1, BranchTarget=0x100, Jump=1, JumpReg=1 same edge → PC=0x100, IF_ID_Valid=0, StallCount unchanged.
- JumpReg=1, JumpRegAddr=0x00000203 → PC=0x00000200. Jump=1 with IF_ID_Valid=0 → ignored, PC+4.
- Rst_n pulsed low mid-cycle during a stall at PC=0x80 → outputs clear immediately. After release IMemAddr=RESET_PC. Counters restart at 0. FetchCount preloaded near saturation is held at all-ones.

Source files
------------

// File: rtl/instruction_fetch_stage_if.sv
// Signal bundle between the fetch stage and its neighbours: instruction memory,
// hazard/redirect control from ID/EX, the IF/ID register and its decoded fields.
interface instruction_fetch_stage_if #(
    parameter int CNT_W = 32
);
    // Instruction memory: combinational read, IMemData answers IMemAddr in the same cycle.
    logic [31:0]      IMemAddr;
    logic [31:0]      IMemData;

    // Pipeline control from hazard unit, EX and Controller.
    logic             Stall;
    logic             BranchTaken;
    logic [31:0]      BranchTarget;
    logic             Jump;
    logic             JumpReg;
    logic [31:0]      JumpRegAddr;

    // IF/ID contents. IF_ID_Valid qualifies every other IF/ID field: when it is 0
    // the register holds a bubble (nop) and downstream must not act on it. There is
    // no ready; back-pressure is expressed only through Stall.
    logic             IF_ID_Valid;
    logic [31:0]      IF_ID_Instr;
    logic [31:0]      IF_ID_PCPlus4;

    // Decoder fields sliced from IF_ID_Instr.
    logic [5:0]       OPCode;
    logic [4:0]       Rs;
    logic [4:0]       TargetReg;
    logic [4:0]       Rd;
    logic [4:0]       Shamt;
    logic [5:0]       Function;
    logic [31:0]      ImmSExt;

    // Saturating performance counters.
    logic [CNT_W-1:0] FetchCount;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output IMemAddr,
        input  IMemData,
        input  Stall, BranchTaken, BranchTarget, Jump, JumpReg, JumpRegAddr,
        output IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4,
        output OPCode, Rs, TargetReg, Rd, Shamt, Function, ImmSExt,
        output FetchCount, StallCount
    );

    modport slave (
        input  IMemAddr,
        output IMemData,
        output Stall, BranchTaken, BranchTarget, Jump, JumpReg, JumpRegAddr,
        input  IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4,
        input  OPCode, Rs, TargetReg, Rd, Shamt, Function, ImmSExt,
        input  FetchCount, StallCount
    );
endinterface

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: PC register with prioritised redirects, IF/ID pipeline register
// with stall/flush, decoder field split and saturating fetch/stall counters.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic                        Clk,
    input  logic                        Rst_n,
    instruction_fetch_stage_if.master   bus
);

    logic [31:0]      pc_q,        pc_d;
    logic [31:0]      if_instr_q,  if_instr_d;
    logic [31:0]      if_pc4_q,    if_pc4_d;
    logic             if_valid_q,  if_valid_d;
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [31:0]      pc_plus4;
    logic             jump_take;
    logic             jr_take;
    logic             redirect;
    logic             load_valid;
    logic             stall_count_en;

    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        // Jumps belong to the instruction in IF/ID, so a bubble cannot jump.
        jump_take      = bus.Jump    && if_valid_q;
        jr_take        = bus.JumpReg && if_valid_q;
        redirect       = bus.BranchTaken || jr_take || jump_take;
        load_valid     = !redirect && !bus.Stall;
        stall_count_en = !redirect && bus.Stall;

        pc_d       = pc_plus4;
        if_instr_d = bus.IMemData;
        if_pc4_d   = pc_plus4;
        if_valid_d = 1'b1;

        if (bus.BranchTaken) begin
            pc_d = {bus.BranchTarget[31:2], 2'b00};
        end else if (jr_take) begin
            pc_d = {bus.JumpRegAddr[31:2], 2'b00};
        end else if (jump_take) begin
            pc_d = {if_pc4_q[31:28], if_instr_q[25:0], 2'b00};
        end else if (bus.Stall) begin
            pc_d = pc_q;
        end

        // A redirect kills the word fetched this cycle: it is on the wrong path.
        if (redirect) begin
            if_instr_d = 32'd0;
            if_pc4_d   = 32'd0;
            if_valid_d = 1'b0;
        end else if (bus.Stall) begin
            if_instr_d = if_instr_q;
            if_pc4_d   = if_pc4_q;
            if_valid_d = if_valid_q;
        end

        fetch_cnt_d = fetch_cnt_q;
        if (load_valid && (fetch_cnt_q != {CNT_W{1'b1}})) begin
            fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
        end

        stall_cnt_d = stall_cnt_q;
        if (stall_count_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pc_q        <= RESET_PC;
            if_instr_q  <= 32'd0;
            if_pc4_q    <= 32'd0;
            if_valid_q  <= 1'b0;
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            if_instr_q  <= if_instr_d;
            if_pc4_q    <= if_pc4_d;
            if_valid_q  <= if_valid_d;
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.IMemAddr      = pc_q;
    assign bus.IF_ID_Valid   = if_valid_q;
    assign bus.IF_ID_Instr   = if_instr_q;
    assign bus.IF_ID_PCPlus4 = if_pc4_q;

    assign bus.OPCode    = if_instr_q[31:26];
    assign bus.Rs        = if_instr_q[25:21];
    assign bus.TargetReg = if_instr_q[20:16];
    assign bus.Rd        = if_instr_q[15:11];
    assign bus.Shamt     = if_instr_q[10:6];
    assign bus.Function  = if_instr_q[5:0];
    assign bus.ImmSExt   = {{16{if_instr_q[15]}}, if_instr_q[15:0]};

    assign bus.FetchCount = fetch_cnt_q;
    assign bus.StallCount = stall_cnt_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: sequential fetch, jump/branch/JR
// redirects, stall, priority, counter saturation and asynchronous reset.
module tb_instruction_fetch_stage;

  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  instruction_fetch_stage_if #(.CNT_W(CNT_W)) ifc ();

  instruction_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .CNT_W    (CNT_W)
  ) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (ifc)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory: address-tagged words plus two hand-placed instructions
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a)
      32'h0040_0004: imem_word = 32'h0800_0010;  // j 0x40
      32'h0000_0040: imem_word = 32'h8C43_8004;  // lw $3,-32764($2)
      default:       imem_word = 32'hA000_0000 | a;
    endcase
  endfunction

  always_comb ifc.IMemData = imem_word(ifc.IMemAddr);

  // checking
  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // driver
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_ctrl();
    ifc.Stall        = 1'b0;
    ifc.BranchTaken  = 1'b0;
    ifc.BranchTarget = 32'd0;
    ifc.Jump         = 1'b0;
    ifc.JumpReg      = 1'b0;
    ifc.JumpRegAddr  = 32'd0;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc, input logic valid,
                            input logic [31:0] instr, input logic [31:0] pc4);
    check_eq({tag, ".pc"},    ifc.IMemAddr, pc);
    check_eq({tag, ".valid"}, {31'd0, ifc.IF_ID_Valid}, {31'd0, valid});
    check_eq({tag, ".instr"}, ifc.IF_ID_Instr, instr);
    check_eq({tag, ".pc4"},   ifc.IF_ID_PCPlus4, pc4);
  endtask

  task automatic check_cnt(input string tag, input int fetches, input int stalls);
    check_eq({tag, ".fetch_cnt"}, {28'd0, ifc.FetchCount}, 32'(fetches));
    check_eq({tag, ".stall_cnt"}, {28'd0, ifc.StallCount}, 32'(stalls));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    clear_ctrl();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick();
    tick();

    // reset state
    check_ifid("reset", 32'h0, 1'b0, 32'h0, 32'h0);
    check_cnt("reset", 0, 0);
    check_eq("reset.opcode", {26'd0, ifc.OPCode}, 32'd0);
    check_eq("reset.funct",  {26'd0, ifc.Function}, 32'd0);
    check_eq("reset.imm",    ifc.ImmSExt, 32'd0);

    // sequential fetch from RESET_PC, no stall
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check_ifid("seq", 32'(4 * i), 1'b1, 32'hA000_0000 | 32'(4 * (i - 1)), 32'(4 * i));
      check_eq("seq.fetch_cnt", {28'd0, ifc.FetchCount}, 32'(i));
    end

    // stall three cycles at PC=0x20
    ifc.Stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_ifid("stall", 32'h20, 1'b1, 32'hA000_001C, 32'h20);
      check_cnt("stall", 8, i);
    end
    ifc.Stall = 1'b0;
    tick();
    check_ifid("stall_rel", 32'h24, 1'b1, 32'hA000_0020, 32'h24);
    check_cnt("stall_rel", 9, 3);

    // branch to the J instruction
    ifc.BranchTaken  = 1'b1;
    ifc.BranchTarget = 32'h0040_0004;
    tick();
    check_ifid("br", 32'h0040_0004, 1'b0, 32'h0, 32'h0);
    check_cnt("br", 9, 3);
    clear_ctrl();
    tick();
    check_ifid("j_in_ifid", 32'h0040_0008, 1'b1, 32'h0800_0010, 32'h0040_0008);
    check_eq("j.opcode", {26'd0, ifc.OPCode}, 32'h2);
    check_eq("j.funct",  {26'd0, ifc.Function}, 32'h10);
    check_eq("j.imm",    ifc.ImmSExt, 32'h10);

    // Jump taken; then Jump held on the resulting bubble must be ignored
    ifc.Jump = 1'b1;
    tick();
    check_ifid("jump", 32'h40, 1'b0, 32'h0, 32'h0);
    check_cnt("jump", 10, 3);
    tick();
    check_ifid("jump_bubble", 32'h44, 1'b1, 32'h8C43_8004, 32'h44);
    check_cnt("jump_bubble", 11, 3);
    check_eq("lw.opcode", {26'd0, ifc.OPCode},    32'h23);
    check_eq("lw.rs",     {27'd0, ifc.Rs},        32'h2);
    check_eq("lw.rt",     {27'd0, ifc.TargetReg}, 32'h3);
    check_eq("lw.rd",     {27'd0, ifc.Rd},        32'h10);
    check_eq("lw.shamt",  {27'd0, ifc.Shamt},     32'h0);
    check_eq("lw.funct",  {26'd0, ifc.Function},  32'h4);
    check_eq("lw.imm",    ifc.ImmSExt,            32'hFFFF_8004);
    ifc.Jump = 1'b0;

    // JumpReg with a misaligned register value
    ifc.JumpReg     = 1'b1;
    ifc.JumpRegAddr = 32'h0000_0203;
    tick();
    check_ifid("jr", 32'h200, 1'b0, 32'h0, 32'h0);
    clear_ctrl();
    tick();
    check_ifid("jr_next", 32'h204, 1'b1, 32'hA000_0200, 32'h204);
    check_cnt("jr_next", 12, 3);

    // everything at once: branch wins, stall not counted
    ifc.Stall        = 1'b1;
    ifc.BranchTaken  = 1'b1;
    ifc.BranchTarget = 32'h100;
    ifc.Jump         = 1'b1;
    ifc.JumpReg      = 1'b1;
    ifc.JumpRegAddr  = 32'h300;
    tick();
    check_ifid("prio", 32'h100, 1'b0, 32'h0, 32'h0);
    check_cnt("prio", 12, 3);
    clear_ctrl();
    tick();
    check_ifid("prio_next", 32'h104, 1'b1, 32'hA000_0100, 32'h104);

    // fetch counter saturates at all-ones
    tick();
    check_cnt("sat1", 14, 3);
    tick();
    check_cnt("sat2", 15, 3);
    tick();
    check_cnt("sat3", 15, 3);
    check_eq("sat3.pc", ifc.IMemAddr, 32'h110);

    // stall counter saturates too
    ifc.Stall = 1'b1;
    repeat (13) tick();
    check_cnt("stall_sat", 15, 15);
    check_eq("stall_sat.pc", ifc.IMemAddr, 32'h110);

    // branch to 0x80 under stall, then keep stalling and reset mid-cycle
    ifc.BranchTaken  = 1'b1;
    ifc.BranchTarget = 32'h80;
    tick();
    check_eq("br80.pc", ifc.IMemAddr, 32'h80);
    ifc.BranchTaken = 1'b0;
    tick();
    check_ifid("stall80", 32'h80, 1'b0, 32'h0, 32'h0);
    #3;
    ifc.BranchTaken  = 1'b1;
    ifc.BranchTarget = 32'h500;
    rst_n = 1'b0;
    #1;
    check_ifid("midrst", 32'h0, 1'b0, 32'h0, 32'h0);
    check_cnt("midrst", 0, 0);
    tick();
    check_ifid("midrst_hold", 32'h0, 1'b0, 32'h0, 32'h0);
    clear_ctrl();
    rst_n = 1'b1;
    tick();
    check_ifid("after_rst", 32'h4, 1'b1, 32'hA000_0000, 32'h4);
    check_cnt("after_rst", 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
